// File: rtl/prescale_counter.sv
// Prescaled up/down accumulator: a down-counting prescaler strobes every eff_div enabled cycles
// and the accumulator steps on each strobe. Define PRESCALE_COUNTER_SAT_EN to saturate instead of wrap.
module prescale_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [WIDTH-1:0]     step,
  input  logic                 dir,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 wrap
);

  logic [DIV_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [DIV_WIDTH-1:0] eff_div;
  logic [WIDTH-1:0]     count_q, count_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic [WIDTH:0]       sum, diff;
  logic                 ovf;
  logic [WIDTH-1:0]     acc_next;

  assign eff_div = (div == '0) ? DIV_WIDTH'(1) : div;

  // Extra top bit captures carry (up) or borrow (down).
  assign sum  = {1'b0, count_q} + {1'b0, step};
  assign diff = {1'b0, count_q} - {1'b0, step};

  always_comb begin
    ovf = dir ? diff[WIDTH] : sum[WIDTH];
`ifdef PRESCALE_COUNTER_SAT_EN
    if (ovf) begin
      acc_next = dir ? '0 : '1;
    end else begin
      acc_next = dir ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
    end
`else
    acc_next = dir ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
`endif
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (clr) begin
      pre_cnt_d = '0;
      count_d   = '0;
    end else if (en) begin
      if (pre_cnt_q == '0) begin
        // div is only sampled here, so a mid-period change never shortens a period.
        pre_cnt_d = eff_div - DIV_WIDTH'(1);
        count_d   = acc_next;
        tick_d    = 1'b1;
        wrap_d    = ovf;
      end else begin
        pre_cnt_d = pre_cnt_q - DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_prescale_counter.sv
// Directed self-checking bench for prescale_counter; expected accumulator values come from a
// small reference model that honours PRESCALE_COUNTER_SAT_EN.
module tb_prescale_counter;

  logic       clk = 1'b0;
  logic       rst, en, clr, dir;
  logic [7:0] div, step;
  logic [7:0] count;
  logic       tick, wrap;

  int errors = 0;
  int checks = 0;
  int mc;
  bit mw;

  always #5 clk = ~clk;

  prescale_counter #(
    .WIDTH     (8),
    .DIV_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .div   (div),
    .step  (step),
    .dir   (dir),
    .count (count),
    .tick  (tick),
    .wrap  (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit exp_tick, input bit exp_wrap);
    chk({tag, "_count"}, {24'd0, count}, mc);
    chk({tag, "_tick"}, {31'd0, tick}, {31'd0, exp_tick});
    chk({tag, "_wrap"}, {31'd0, wrap}, {31'd0, exp_wrap});
  endtask

  // Reference accumulator update for one tick event.
  task automatic model(input int s, input bit d);
    int r;
    r  = d ? (mc - s) : (mc + s);
    mw = (r > 255) || (r < 0);
`ifdef PRESCALE_COUNTER_SAT_EN
    if (r > 255) r = 255;
    else if (r < 0) r = 0;
`else
    r = r & 255;
`endif
    mc = r;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; div = 8'd4; step = 8'd1; dir = 1'b0;
    mc = 0;
    cyc; cyc;
    chk_out("reset", 1'b0, 1'b0);

    // Divide by 4, step 1: events on edges 1,5,9,13,17.
    rst = 1'b0; en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (n % 4 == 1) begin
        model(1, 1'b0);
        cyc;
        chk_out($sformatf("div4_e%0d", n), 1'b1, mw);
      end else begin
        cyc;
        chk_out($sformatf("div4_e%0d", n), 1'b0, 1'b0);
      end
    end
    chk("div4_final", {24'd0, count}, 32'd5);

    clr = 1'b1; cyc; mc = 0;
    chk_out("clr_a", 1'b0, 1'b0);
    clr = 1'b0;

    // div=0 behaves as 1: tick every cycle, wrap 255 -> 2 on edge 86.
    div = 8'd0; step = 8'd3;
    for (int n = 1; n <= 86; n++) begin
      model(3, 1'b0);
      cyc;
      chk_out($sformatf("div0_e%0d", n), 1'b1, mw);
    end
    chk("div0_wrap_edge", {31'd0, wrap}, 32'd1);
    div = 8'd1;
    for (int n = 1; n <= 4; n++) begin
      model(3, 1'b0);
      cyc;
      chk_out($sformatf("div1_e%0d", n), 1'b1, mw);
    end

    // Down underflow from 2 by 5.
    clr = 1'b1; cyc; mc = 0;
    chk_out("clr_b", 1'b0, 1'b0);
    clr = 1'b0; div = 8'd0; step = 8'd2; dir = 1'b0;
    model(2, 1'b0); cyc;
    chk_out("down_pre", 1'b1, 1'b0);
    dir = 1'b1; step = 8'd5; div = 8'd2;
    model(5, 1'b1); cyc;
    chk_out("down_under", 1'b1, mw);
    chk("down_under_wrap", {31'd0, wrap}, 32'd1);
    step = 8'd0;
    cyc;
    chk_out("step0_idle", 1'b0, 1'b0);
    model(0, 1'b1); cyc;
    chk_out("step0_event", 1'b1, 1'b0);

    // div 4 -> 2 mid-period: current period still 4 cycles, then 2.
    clr = 1'b1; cyc; mc = 0;
    chk_out("clr_c", 1'b0, 1'b0);
    clr = 1'b0; dir = 1'b0; step = 8'd1; div = 8'd4;
    model(1, 1'b0); cyc; chk_out("dchg_e1", 1'b1, 1'b0);
    cyc; chk_out("dchg_e2", 1'b0, 1'b0);
    div = 8'd2;
    cyc; chk_out("dchg_e3", 1'b0, 1'b0);
    cyc; chk_out("dchg_e4", 1'b0, 1'b0);
    model(1, 1'b0); cyc; chk_out("dchg_e5", 1'b1, 1'b0);
    cyc; chk_out("dchg_e6", 1'b0, 1'b0);
    model(1, 1'b0); cyc; chk_out("dchg_e7", 1'b1, 1'b0);

    // Clear collides with a due event at count=7.
    step = 8'd4;
    cyc; chk_out("clr_col_e8", 1'b0, 1'b0);
    model(4, 1'b0); cyc; chk_out("clr_col_e9", 1'b1, 1'b0);
    chk("clr_col_cnt7", {24'd0, count}, 32'd7);
    cyc; chk_out("clr_col_e10", 1'b0, 1'b0);
    clr = 1'b1; cyc; mc = 0;
    chk_out("clr_col_e11", 1'b0, 1'b0);
    clr = 1'b0;
    model(4, 1'b0); cyc; chk_out("clr_col_e12", 1'b1, 1'b0);

    // Async reset mid-cycle at count=9, then en 1/0/1 freezes the prescaler.
    step = 8'd5;
    cyc; chk_out("arst_e13", 1'b0, 1'b0);
    model(5, 1'b0); cyc; chk_out("arst_e14", 1'b1, 1'b0);
    chk("arst_cnt9", {24'd0, count}, 32'd9);
    #2 rst = 1'b1;
    #1 mc = 0;
    chk_out("arst_async", 1'b0, 1'b0);
    #1 rst = 1'b0;
    step = 8'd1; div = 8'd2; en = 1'b1;
    model(1, 1'b0); cyc; chk_out("frz_a", 1'b1, 1'b0);
    en = 1'b0;
    cyc; chk_out("frz_b", 1'b0, 1'b0);
    en = 1'b1;
    cyc; chk_out("frz_c", 1'b0, 1'b0);
    model(1, 1'b0); cyc; chk_out("frz_d", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
